// File: rtl/io_button_reader_pkg.sv
// Shared constants for the Io board button reader: button indices, count and 100 MHz timing.
// Optional auto-repeat is enabled by defining IO_BUTTON_REPEAT_EN.
package io_button_reader_pkg;

    localparam int BTN_UP     = 0;
    localparam int BTN_CENTER = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_RIGHT  = 4;
    localparam int IO_N_BTN   = 5;

    localparam int IO_DEBOUNCE_CYCLES = 2_000_000;   // 20 ms
    localparam int IO_REPEAT_DELAY    = 50_000_000;  // 0.5 s
    localparam int IO_REPEAT_PERIOD   = 10_000_000;  // 0.1 s

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/io_button_reader_debounce.sv
// One button: 2-flop synchronizer, debounce counter, press/release pulses and,
// when IO_BUTTON_REPEAT_EN is defined, a typematic auto-repeat FSM.
module button_debounce
    import io_button_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = IO_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = IO_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_debounce: illegal timing parameters");
    end

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic          r_press;
    logic          r_release;
    logic [CW-1:0] r_cnt;

    logic w_accept;
    logic w_rise;
    logic w_fall;
    logic w_rep_fire;

    assign w_accept = (r_s2 != r_stable) && (r_cnt == CNT_LAST);
    assign w_rise   = w_accept &  r_s2;
    assign w_fall   = w_accept & ~r_s2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_button;
            r_s2 <= r_s1;
        end
    end

    // Pulses are registered alongside the stable level so they coincide with its first new cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable  <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_rise | w_rep_fire;
            r_release <= w_fall;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef IO_BUTTON_REPEAT_EN
    localparam int            RW      = $clog2(max_int(max_int(REPEAT_DELAY, REPEAT_PERIOD), 2));
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    rpt_state_t    r_state;
    logic [RW-1:0] r_rcnt;

    // A release accepted in the same cycle cancels any repeat that would have fired.
    assign w_rep_fire = ~w_fall &&
                        (((r_state == RPT_DELAY)  && (r_rcnt == RD_LAST)) ||
                         ((r_state == RPT_REPEAT) && (r_rcnt == RP_LAST)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RPT_IDLE;
            r_rcnt  <= '0;
        end else if (w_fall) begin
            r_state <= RPT_IDLE;
            r_rcnt  <= '0;
        end else begin
            case (r_state)
                RPT_IDLE: begin
                    r_rcnt <= '0;
                    if (w_rise) r_state <= RPT_DELAY;
                end
                RPT_DELAY: begin
                    if (r_rcnt == RD_LAST) begin
                        r_state <= RPT_REPEAT;
                        r_rcnt  <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (r_rcnt == RP_LAST) r_rcnt <= '0;
                    else                   r_rcnt <= r_rcnt + 1'b1;
                end
                default: begin
                    r_state <= RPT_IDLE;
                    r_rcnt  <= '0;
                end
            endcase
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign o_level   = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/io_button_reader.sv
// Io board button conditioner: one button_debounce per input line.
// Define IO_BUTTON_REPEAT_EN to add auto-repeat press pulses while a button is held.
module io_button_reader
    import io_button_reader_pkg::*;
#(
    parameter int N_BTN           = IO_N_BTN,
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = IO_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = IO_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] io_button,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .i_button  (io_button[i]),
            .o_level   (btn_level[i]),
            .o_press   (btn_press[i]),
            .o_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_io_button_reader.sv
// Self-checking bench for io_button_reader: directed scenarios plus random stimulus
// compared every cycle against a sliding-window reference model.
module tb_io_button_reader;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef IO_BUTTON_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] io_button;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    io_button_reader #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io_button   (io_button),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Reference model: a change is accepted once the raw input, seen two edges late,
    // has disagreed with the accepted level on each of the last D edges.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_level, m_press, m_release;
    int           press_edge[N];
    int           edge_no;
    int           n_press[N];

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j <= D; j++) hist.push_back('0);
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        edge_no   = 0;
    endtask

    task automatic model_step(input logic [N-1:0] x);
        m_press   = '0;
        m_release = '0;
        edge_no++;
        for (int i = 0; i < N; i++) begin
            bit all_diff = 1'b1;
            for (int j = 0; j < D; j++)
                if (hist[1+j][i] == m_level[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[i] = ~m_level[i];
                if (m_level[i]) begin
                    m_press[i]    = 1'b1;
                    press_edge[i] = edge_no;
                end else begin
                    m_release[i] = 1'b1;
                end
            end else if (REP && m_level[i]) begin
                int n = edge_no - press_edge[i];
                if (n >= RD && ((n - RD) % RP) == 0) m_press[i] = 1'b1;
            end
        end
        hist.push_front(x);
        void'(hist.pop_back());
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (v) model_reset();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(io_button);
        @(negedge clk);
        check("level",   btn_level,   m_level);
        check("press",   btn_press,   m_press);
        check("release", btn_release, m_release);
        for (int i = 0; i < N; i++) n_press[i] += int'(btn_press[i]);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) n_press[i] = 0;
    endtask

    initial begin
        io_button = '1;
        model_reset();
        set_rst(1'b1);
        #1;
        check("reset_level",   btn_level,   '0);
        check("reset_press",   btn_press,   '0);
        check("reset_release", btn_release, '0);
        ticks(3);
        set_rst(1'b0);

        // Buttons held through reset become fresh presses on edge 6.
        ticks(5);
        check("held_rst_pre", btn_press, '0);
        tick();
        check("held_rst_press", btn_press, 5'b11111);
        check("held_rst_level", btn_level, 5'b11111);
        io_button = '0;
        ticks(12);

        // Clean press and release on bit 0.
        io_button[0] = 1'b1;
        ticks(5);
        check("press0_pre", btn_level & 5'b00001, 5'b00000);
        tick();
        check("press0_edge6", btn_press, 5'b00001);
        tick();
        check("press0_once", btn_press & 5'b00001, 5'b00000);
        io_button[0] = 1'b0;
        ticks(5);
        tick();
        check("release0_edge6", btn_release, 5'b00001);
        check("release0_level", btn_level, 5'b00000);
        ticks(30);

        // Bounce on bit 1: 3 high / 1 low never settles.
        clear_counts();
        for (int k = 0; k < 40; k++) begin
            io_button[1] = (k % 4) != 3;
            tick();
        end
        check("bounce_no_press", N'(n_press[1]), N'(0));
        check("bounce_level",    btn_level, 5'b00000);
        io_button[1] = 1'b1;
        ticks(10);
        check("bounce_one_press", N'(n_press[1]), N'(1));
        io_button[1] = 1'b0;
        ticks(30);

        // Bits 2 and 4 together.
        io_button = 5'b10100;
        ticks(5);
        tick();
        check("simul_press", btn_press, 5'b10100);
        io_button = '0;
        ticks(30);

        // Reset in the middle of a bit-3 debounce.
        clear_counts();
        io_button[3] = 1'b1;
        ticks(3);
        set_rst(1'b1);
        ticks(2);
        set_rst(1'b0);
        ticks(5);
        check("rst_abort_none", N'(n_press[3]), N'(0));
        tick();
        check("rst_abort_press", btn_press, 5'b01000);
        io_button = '0;
        ticks(30);

        // Hold bit 0 well past the press.
        clear_counts();
        io_button[0] = 1'b1;
        ticks(6 + 50);
        check("repeat_count", N'(n_press[0]), REP ? N'(5) : N'(1));
        io_button[0] = 1'b0;
        ticks(40);
        clear_counts();
        ticks(40);
        check("after_release", N'(n_press[0]), N'(0));

        // Random bouncy noise, then random holds with occasional resets.
        for (int k = 0; k < 300; k++) begin
            io_button = N'($urandom);
            tick();
        end
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) io_button[i] = ~io_button[i];
            if ($urandom_range(0, 399) == 0) begin
                set_rst(1'b1);
                tick();
                set_rst(1'b0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
